// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Parity type encoding as seen by the parity calculator
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority pick: the first set request found scanning
// upward from ptr+1 (with wrap) wins, so the last winner has lowest priority.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               any_valid
);

    int idx;

    // Scan from the farthest offset down to the nearest; the nearest set request overwrites last
    always_comb begin
        idx       = 0;
        winner    = '0;
        any_valid = |req;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (req[idx]) begin
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. Latches the winner's byte and parity setup, strobes the TX FSM,
// then follows tx_busy until the frame completes or never starts.
//
// Handshake: a producer raises req_valid[i] with req_data/cfg_* stable and
// holds it until it sees the one-cycle req_ack[i]; the byte is owned by the
// arbiter from that cycle on. Toward the transmitter, tx_data_valid is a
// one-cycle strobe issued only while tx_busy is low; tx_busy rising is the
// transmitter's acceptance and tx_busy falling marks the end of the frame.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            cfg_par_en,
    input  logic [NUM_REQ-1:0]            cfg_par_typ,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          tx_busy,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_data_valid,
    output logic                          tx_par_en,
    output logic                          tx_par_typ,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          frame_done,
    output logic                          timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(BUSY_TIMEOUT + 1);
    // Counter value during the last WAIT_BUSY cycle before the frame is abandoned
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   to_cnt;
    logic [IDW-1:0]  win_idx;
    logic            any_valid;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .winner    (win_idx),
        .any_valid (any_valid)
    );

    // Scheduler FSM; every output is a register, strobes default low each cycle.
    // WAIT_BUSY lasts at most BUSY_TIMEOUT cycles; timeout_err then shows in the
    // following IDLE cycle, BUSY_TIMEOUT cycles after GRANT ends.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            rr_ptr        <= IDW'(NUM_REQ - 1);
            to_cnt        <= '0;
            req_ack       <= '0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            tx_par_en     <= 1'b0;
            tx_par_typ    <= PAR_EVEN;
            grant_id      <= '0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            req_ack       <= '0;
            tx_data_valid <= 1'b0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_busy && any_valid) begin
                        tx_p_data     <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                        tx_par_en     <= cfg_par_en[win_idx];
                        tx_par_typ    <= cfg_par_typ[win_idx];
                        grant_id      <= win_idx;
                        rr_ptr        <= win_idx;
                        req_ack       <= ONE_HOT0 << win_idx;
                        tx_data_valid <= 1'b1;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    to_cnt <= '0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter (serializer + TX FSM) among NUM_REQ byte producers. It accepts one byte from the winning requester and applies that requester's parity configuration. It issues a single-cycle data-valid strobe, then tracks the transmitter's busy flag until the frame completes. It reports completion, or a start-timeout, per frame and sits between the producer blocks and the UART TX top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width driven to the transmitter
BUSY_TIMEOUT, 15, max cycles in WAIT_BUSY before the frame is abandoned (>=2)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte pending; held until matching req_ack
req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
cfg_par_en  input  NUM_REQ  per-requester parity enable
cfg_par_typ  input  NUM_REQ  per-requester parity type (0 even, 1 odd)
req_ack  output  NUM_REQ  one-hot, one-cycle pulse: byte accepted
tx_busy  input  1  busy from the UART TX FSM
tx_p_data  output  DATA_WIDTH  byte to the serializer
tx_data_valid  output  1  one-cycle start strobe to the TX FSM
tx_par_en  output  1  parity enable to the TX FSM/parity calc
tx_par_typ  output  1  parity type to the parity calc
grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester
frame_done  output  1  one-cycle pulse: granted frame fully sent
timeout_err  output  1  one-cycle pulse: tx_busy never rose, frame dropped

Behaviour:
- Reset (async, RST=0): state IDLE; all outputs 0; timeout counter 0; rr pointer = NUM_REQ-1, so requester 0 has top priority after reset.
- All outputs are registered; no combinational input-to-output paths.
- IDLE: arbitrate only when tx_busy=0 and any req_valid=1.
  - Winner is the first requester with valid set, scanning upward from pointer+1 with wrap-around.
  - On the edge: latch the winner's req_data, cfg_par_en and cfg_par_typ into tx_p_data, tx_par_en, tx_par_typ; set grant_id; pointer = winner; go to GRANT.
- GRANT (exactly 1 cycle): tx_data_valid=1 and req_ack[grant_id]=1 in the same cycle; clear the counter; go to WAIT_BUSY.
- WAIT_BUSY: counter increments each cycle.
  - tx_busy=1: go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT with tx_busy still 0: pulse timeout_err (registered, in the following IDLE cycle) and return to IDLE; the byte is dropped and the pointer stays advanced.
- WAIT_DONE: on tx_busy=0, go to IDLE and pulse frame_done in that IDLE cycle.
- tx_p_data, tx_par_en and tx_par_typ hold stable from GRANT until the next grant; later cfg_* changes never affect an in-flight frame.
- Latency: req_valid sampled in IDLE, then req_ack and tx_data_valid on the next cycle.
- Back-to-back: arbitration may occur in the same IDLE cycle that carries frame_done, giving a minimum 1 IDLE cycle between frames.
- Simultaneous requests are served in strict rotation; a continuously asserting requester cannot starve the others (max wait NUM_REQ-1 frames).
- A requester dropping req_valid before ack has no effect once its byte is latched. If it drops before being chosen, it is not served.
- Asynchronous reset mid-frame returns to IDLE immediately and clears all strobes. The UART is reset by the same RST.
- Illegal or unused state encodings go to IDLE.

Decomposition:
- Shared package uart_tx_pkg:
  - state encoding localparams: IDLE, GRANT, WAIT_BUSY, WAIT_DONE
  - parity-type constants: PAR_EVEN=0, PAR_ODD=1
  - default DATA_WIDTH
- One sub-module, uart_rr_arbiter: combinational rotate-priority pick.
  - Inputs: req vector, pointer.
  - Outputs: winner index, any_valid.
- The FSM, latches, timeout counter and pointer register live in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=0001, data 8'hA5, cfg_par_en[0]=1, cfg_par_typ[0]=0 -> next cycle req_ack=0001, tx_data_valid=1, tx_p_data=A5, tx_par_en=1, tx_par_typ=0. Model busy high for 11 cycles, then frame_done pulses once and grant_id=0.
- Simultaneous requests: req_valid=1010 after reset -> grant order 1, then 3, with ack pulses 0010 then 1000. A new request from 0 during frame 1 is served after 3.
- Continuous requests: all four held valid for 8 frames -> grant sequence 0,1,2,3,0,1,2,3. Each ack is one cycle wide and frame_done count = 8.
- Timeout: busy model held 0 after a grant of requester 2 -> timeout_err pulses exactly BUSY_TIMEOUT cycles after GRANT and frame_done stays 0. The next grant goes to requester 3 if valid.
- Per-requester parity: req 0 with par_en=1/odd and req 1 with par_en=0 -> tx_par_en/tx_par_typ equal 1/1 then 0/x. A cfg_par_typ[0] flip mid-frame leaves tx_par_typ unchanged.
- Reset mid-frame: RST low during WAIT_DONE -> all outputs 0 immediately. After release, pending requests 0 and 2 are served 0 first.
